// File: rtl/pkt_pack_64to128.sv
// rtl/pkt_pack_64to128.sv - 64-bit to 128-bit Avalon-ST packet packer
//
// Packs pairs of 64-bit input beats into 128-bit output beats. The first
// beat of a pair lands in [127:64]. Odd-length packets finish with a
// zero-padded lower half and an out_empty that counts the padding.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_data/valid/ready          64-bit input beat and handshake
//   in_sop/eop/empty             input framing; in_empty counts unused LSB bytes
//   out_data/valid/ready         128-bit output beat and handshake
//   out_sop/eop/empty            output framing; out_empty is 0..15
//   pkt_count                    packets emitted (eop beats transferred), wraps
//   drop_count                   orphan beats discarded, wraps
//   err_sop, err_orphan          sticky protocol-error flags, cleared by reset only
module pkt_pack_64to128 #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [63:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [2:0]         in_empty,
  output logic [127:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [3:0]         out_empty,
  output logic [COUNT_W-1:0] pkt_count,
  output logic [COUNT_W-1:0] drop_count,
  output logic               err_sop,
  output logic               err_orphan
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]   state;
  logic [63:0]  pend_data;
  logic         pend_sop;
  logic         in_pkt;

  logic         accept;
  logic         orphan;
  logic         restart;
  logic         use_half;
  logic         load;
  logic [127:0] load_data;
  logic         load_sop;
  logic         load_eop;
  logic [3:0]   load_empty;

  // The single output register is the only buffering: a new beat may be
  // taken whenever that register is free or is being emptied this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign orphan   = accept && !in_sop && !in_pkt;
  assign restart  = accept && in_sop && in_pkt;
  // A sop beat always starts fresh, so any pending half is abandoned.
  assign use_half = (state == ST_HALF) && !in_sop;

  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_sop   = 1'b0;
    load_eop   = 1'b0;
    load_empty = '0;
    if (accept && !orphan) begin
      if (use_half) begin
        load       = 1'b1;
        load_data  = {pend_data, in_data};
        load_sop   = pend_sop;
        load_eop   = in_eop;
        load_empty = in_eop ? {1'b0, in_empty} : 4'd0;
      end else if (in_eop) begin
        // Lone eop beat: the missing lower half is 8 more unused bytes.
        load       = 1'b1;
        load_data  = {in_data, 64'h0};
        load_sop   = in_sop;
        load_eop   = 1'b1;
        load_empty = 4'd8 + {1'b0, in_empty};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_EMPTY;
      pend_data  <= '0;
      pend_sop   <= 1'b0;
      in_pkt     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_empty  <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
      err_sop    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (accept && !orphan) begin
        if (use_half) begin
          state <= ST_EMPTY;
        end else if (!in_eop) begin
          state     <= ST_HALF;
          pend_data <= in_data;
          pend_sop  <= in_sop;
        end else begin
          state <= ST_EMPTY;
        end
        // Accepted non-orphan beats are either a sop or inside a packet.
        in_pkt <= !in_eop;
      end

      if (orphan) begin
        drop_count <= drop_count + 1'b1;
        err_orphan <= 1'b1;
      end

      if (restart) begin
        err_sop <= 1'b1;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_sop   <= load_sop;
        out_eop   <= load_eop;
        out_empty <= load_empty;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && out_eop) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule
